// File: rtl/race_clock_ctrl.sv
// Race clock controller: countdown, timed run with pause and checkpoint
// bonuses, then a turbo-rate drain of leftover seconds after the finish line.
module race_clock_ctrl #(
  parameter int unsigned RACE_SECS = 60,
  parameter int unsigned MAX_SECS  = 99,
  parameter int unsigned CD_SECS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       finish,
  input  logic       add_time,
  input  logic [3:0] add_secs,
  output logic       turbo,
  output logic [6:0] time_left,
  output logic [1:0] cd_digit,
  output logic       race_active,
  output logic       time_up,
  output logic       bonus_pulse,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSED    = 3'd3,
    S_DRAIN     = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  localparam logic [6:0] MAX7  = 7'(MAX_SECS);
  localparam logic [6:0] RACE7 = 7'(RACE_SECS);
  localparam logic [1:0] CD2   = 2'(CD_SECS);

  state_t     r_state;
  logic [6:0] r_time_left;
  logic [1:0] r_cd_digit;
  logic       r_turbo;
  logic       r_race_active;
  logic       r_time_up;
  logic       r_bonus_pulse;

  state_t     w_next;
  logic [6:0] w_time_left;
  logic [1:0] w_cd_digit;
  logic       w_time_up;
  logic       w_bonus;
  logic [7:0] w_sum;
  logic [7:0] w_net;

  function automatic logic [6:0] clamp(input logic [7:0] v);
    return (v > {1'b0, MAX7}) ? MAX7 : v[6:0];
  endfunction

  // Next-state and next-value decode; arithmetic in 8 bits, then clamped
  always_comb begin
    w_next      = r_state;
    w_time_left = r_time_left;
    w_cd_digit  = r_cd_digit;
    w_time_up   = 1'b0;
    w_bonus     = 1'b0;
    w_sum       = {1'b0, r_time_left} + (add_time ? {4'b0000, add_secs} : 8'd0);
    w_net       = (one_sec && (w_sum != 8'd0)) ? (w_sum - 8'd1) : w_sum;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_next      = S_COUNTDOWN;
          w_time_left = RACE7;
          w_cd_digit  = CD2;
        end
      end
      S_COUNTDOWN: begin
        if (one_sec) begin
          if (r_cd_digit <= 2'd1) begin
            w_cd_digit = '0;
            w_next     = S_RUN;
          end else begin
            w_cd_digit = r_cd_digit - 2'd1;
          end
        end
      end
      S_RUN: begin
        // finish discards a same-cycle tick but keeps a same-cycle bonus;
        // a timeout outranks a same-cycle pause
        if (finish) begin
          w_time_left = clamp(w_sum);
          w_next      = S_DRAIN;
        end else begin
          w_time_left = clamp(w_net);
          if (one_sec && (w_net == 8'd0)) begin
            w_next    = S_OVER;
            w_time_up = 1'b1;
          end else if (pause) begin
            w_next = S_PAUSED;
          end
        end
      end
      S_PAUSED: begin
        w_time_left = clamp(w_sum);
        if (pause) w_next = S_RUN;
      end
      S_DRAIN: begin
        if (r_time_left == '0) begin
          w_next = S_OVER;
        end else if (one_sec) begin
          w_time_left = r_time_left - 7'd1;
          w_bonus     = 1'b1;
          if (r_time_left == 7'd1) w_next = S_OVER;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_time_left   <= '0;
      r_cd_digit    <= '0;
      r_turbo       <= 1'b0;
      r_race_active <= 1'b0;
      r_time_up     <= 1'b0;
      r_bonus_pulse <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_time_left   <= w_time_left;
      r_cd_digit    <= w_cd_digit;
      r_turbo       <= (r_state == S_DRAIN);
      r_race_active <= (w_next == S_RUN);
      r_time_up     <= w_time_up;
      r_bonus_pulse <= w_bonus;
    end
  end

  assign turbo       = r_turbo;
  assign time_left   = r_time_left;
  assign cd_digit    = r_cd_digit;
  assign race_active = r_race_active;
  assign time_up     = r_time_up;
  assign bonus_pulse = r_bonus_pulse;
  assign state       = r_state;

endmodule

// File: tb/tb_race_clock_ctrl.sv
// Directed bench for race_clock_ctrl: vector table plus corner sequences.
module tb_race_clock_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_sec = 1'b0, start = 1'b0, pause = 1'b0, finish = 1'b0, add_time = 1'b0;
  logic [3:0] add_secs = '0;
  logic       turbo, race_active, time_up, bonus_pulse;
  logic [6:0] time_left;
  logic [1:0] cd_digit;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  race_clock_ctrl #(.RACE_SECS(60), .MAX_SECS(99), .CD_SECS(3)) dut (
    .clk(clk), .reset(reset), .one_sec(one_sec), .start(start), .pause(pause),
    .finish(finish), .add_time(add_time), .add_secs(add_secs), .turbo(turbo),
    .time_left(time_left), .cd_digit(cd_digit), .race_active(race_active),
    .time_up(time_up), .bonus_pulse(bonus_pulse), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       os, st, pa, fi, at;
    logic [3:0] as;
    logic [2:0] e_state;
    logic [6:0] e_tl;
    logic [1:0] e_cd;
    logic       e_act;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the rising edge
  task automatic step(input logic os, st, pa, fi, at, input logic [3:0] as);
    one_sec = os; start = st; pause = pa; finish = fi; add_time = at; add_secs = as;
    @(posedge clk);
    #1;
    one_sec = 0; start = 0; pause = 0; finish = 0; add_time = 0; add_secs = '0;
  endtask

  int tu_count;
  int bp_count;

  initial begin
    //             os st pa fi at as  state tl  cd act
    vecs[0]  = '{0, 1, 0, 0, 0, 0,  1, 60, 3, 0};  // start
    vecs[1]  = '{0, 0, 0, 0, 0, 0,  1, 60, 3, 0};  // idle cycle
    vecs[2]  = '{1, 0, 0, 0, 0, 0,  1, 60, 2, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0,  1, 60, 1, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0,  2, 60, 0, 1};  // into RUN
    vecs[5]  = '{1, 0, 0, 0, 0, 0,  2, 59, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 1, 5,  2, 64, 0, 1};
    vecs[7]  = '{1, 0, 0, 0, 1, 9,  2, 72, 0, 1};  // 64+9-1
    vecs[8]  = '{1, 0, 0, 0, 1, 0,  2, 71, 0, 1};  // add 0 is no-op
    vecs[9]  = '{0, 0, 1, 0, 0, 0,  3, 71, 0, 0};  // pause
    vecs[10] = '{1, 0, 0, 0, 0, 0,  3, 71, 0, 0};  // tick ignored while paused
    vecs[11] = '{0, 0, 0, 0, 1, 3,  3, 74, 0, 0};  // bonus while paused
    vecs[12] = '{1, 0, 1, 0, 0, 0,  2, 74, 0, 1};  // resume, tick ignored
    vecs[13] = '{0, 1, 0, 0, 0, 0,  2, 74, 0, 1};  // start ignored in RUN
    vecs[14] = '{1, 0, 1, 0, 0, 0,  3, 73, 0, 0};  // tick + pause
    vecs[15] = '{0, 0, 1, 0, 0, 0,  2, 73, 0, 1};
    vecs[16] = '{1, 0, 0, 0, 1, 15, 2, 87, 0, 1};
    vecs[17] = '{0, 0, 0, 0, 1, 15, 2, 99, 0, 1};  // 102 saturates
    vecs[18] = '{0, 0, 0, 0, 1, 1,  2, 99, 0, 1};
    vecs[19] = '{1, 0, 0, 0, 0, 0,  2, 98, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_tl", time_left, 0);
    chk("rst_cd", cd_digit, 0);
    chk("rst_turbo", turbo, 0);
    chk("rst_active", race_active, 0);
    chk("rst_timeup", time_up, 0);
    chk("rst_bonus", bonus_pulse, 0);
    reset = 0;

    // finish and pause ignored in IDLE
    step(0, 0, 1, 1, 0, 0);
    chk("idle_ignore_state", state, 0);

    foreach (vecs[i]) begin
      step(vecs[i].os, vecs[i].st, vecs[i].pa, vecs[i].fi, vecs[i].at, vecs[i].as);
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_tl", i), time_left, vecs[i].e_tl);
      chk($sformatf("v%0d_cd", i), cd_digit, vecs[i].e_cd);
      chk($sformatf("v%0d_active", i), race_active, vecs[i].e_act);
      chk($sformatf("v%0d_timeup", i), time_up, 0);
    end

    // Full 60-second race from a fresh reset
    reset = 1; #2; reset = 0; #1;
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    chk("race_run_state", state, 2);
    tu_count = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (time_up) tu_count++;
    end
    chk("timeout_state", state, 5);
    chk("timeout_tl", time_left, 0);
    chk("timeout_pulse_now", time_up, 1);
    step(0, 0, 0, 0, 0, 0);
    if (time_up) tu_count++;
    chk("timeout_pulse_count", tu_count, 1);
    chk("timeout_turbo", turbo, 0);
    chk("over_active", race_active, 0);

    // Restart from OVER, climb to 95, then saturating bonus with tick
    step(0, 1, 0, 0, 0, 0);
    chk("restart_tl", time_left, 60);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 15);
    step(0, 0, 0, 0, 1, 15);
    step(0, 0, 0, 0, 1, 5);
    chk("tl_95", time_left, 95);
    step(1, 0, 0, 0, 1, 9);
    chk("sat_tick_tl", time_left, 99);

    // Pause through 5 ticks
    tu_count = 0;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (time_up) tu_count++;
    end
    step(0, 0, 1, 0, 0, 0);
    chk("pause_tl", time_left, 99);
    chk("pause_state", state, 2);
    chk("pause_timeup", tu_count, 0);

    // Run down to 4, then finish with a tick: tick discarded, drain 4
    for (int i = 0; i < 95; i++) step(1, 0, 0, 0, 0, 0);
    chk("tl_4", time_left, 4);
    step(1, 0, 0, 1, 0, 0);
    chk("drain_state", state, 4);
    chk("drain_tl", time_left, 4);
    step(0, 0, 0, 0, 0, 0);
    chk("drain_turbo", turbo, 1);
    bp_count = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (bonus_pulse) bp_count++;
      chk($sformatf("drain_tl_%0d", i), time_left, 3 - i);
    end
    chk("drain_bonus_count", bp_count, 4);
    chk("drain_over_state", state, 5);
    step(0, 0, 0, 0, 0, 0);
    chk("bonus_single", bonus_pulse, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("over_turbo_off", turbo, 0);

    // Asynchronous reset mid-DRAIN
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_rst_turbo", turbo, 1);
    #2;
    reset = 1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_tl", time_left, 0);
    chk("arst_turbo", turbo, 0);
    chk("arst_active", race_active, 0);
    chk("arst_bonus", bonus_pulse, 0);
    reset = 0;
    step(0, 1, 0, 0, 0, 0);
    chk("post_rst_start", state, 1);
    chk("post_rst_timeup", time_up, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/race_clock_ctrl.md
RACE_CLOCK_CTRL -- requirements
Module: race_clock_ctrl

Interface
REQ-001 The block SHALL have parameter RACE_SECS, default 60, initial race time in seconds (1..99).
REQ-002 The block SHALL have parameter MAX_SECS, default 99, saturation ceiling for time_left (RACE_SECS..127).
REQ-003 The block SHALL have parameter CD_SECS, default 3, pre-race countdown length in seconds (1..3).
REQ-004 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous active-high reset (one clock; reset asynchronous and active-high).
REQ-006 The block SHALL have port one_sec  input  1  single-cycle tick from the one-second counter.
REQ-007 The block SHALL have port start  input  1  single-cycle request to begin a race.
REQ-008 The block SHALL have port pause  input  1  single-cycle pause/resume toggle.
REQ-009 The block SHALL have port finish  input  1  single-cycle finish-line crossed.
REQ-010 The block SHALL have port add_time  input  1  single-cycle checkpoint bonus strobe.
REQ-011 The block SHALL have port add_secs  input  4  seconds to add, sampled with add_time.
REQ-012 The block SHALL have port turbo  output  1  rate select driven to the one-second counter.
REQ-013 The block SHALL have port time_left  output  7  remaining race seconds.
REQ-014 The block SHALL have port cd_digit  output  2  countdown digit shown before the race.
REQ-015 The block SHALL have port race_active  output  1  high only in RUN.
REQ-016 The block SHALL have port time_up  output  1  single-cycle pulse on timeout.
REQ-017 The block SHALL have port bonus_pulse  output  1  single-cycle pulse per drained second.
REQ-018 The block SHALL have port state  output  3  encoded state: IDLE=0, COUNTDOWN=1, RUN=2, PAUSED=3, DRAIN=4, OVER=5.

Function
REQ-019 IDLE/OVER: start SHALL load time_left=RACE_SECS, cd_digit=CD_SECS, go COUNTDOWN next cycle; other inputs ignored.
REQ-020 COUNTDOWN: each one_sec SHALL decrement cd_digit; tick with cd_digit==1 SHALL set cd_digit=0 and go RUN.
REQ-021 RUN: one_sec SHALL decrement time_left by 1; tick with time_left==1 SHALL set 0, pulse time_up next cycle, go OVER.
REQ-022 RUN/PAUSED: add_time SHALL add add_secs to time_left, saturating at MAX_SECS; add_secs==0 is a no-op.
REQ-023 RUN: one_sec and add_time in same cycle SHALL apply net time_left+add_secs-1, saturating at MAX_SECS, no timeout unless result is 0.
REQ-024 RUN: pause SHALL go PAUSED; PAUSED: pause SHALL return to RUN; one_sec ignored in PAUSED and time_left held.
REQ-025 RUN: finish SHALL go DRAIN; finish has priority over one_sec and pause in the same cycle (tick discarded); add_time same cycle still applied.
REQ-026 finish SHALL be ignored outside RUN; pause ignored outside RUN/PAUSED; start ignored outside IDLE/OVER.
REQ-027 DRAIN: turbo SHALL be 1; each one_sec SHALL decrement time_left and pulse bonus_pulse same cycle as the decrement; entering DRAIN with time_left==0, or reaching 0, SHALL go OVER.
REQ-028 turbo SHALL be 0 in every state except DRAIN, registered, changing the cycle after state entry.
REQ-029 race_active SHALL be a registered decode of state==RUN; time_up and bonus_pulse never high longer than one cycle.
REQ-030 time_left SHALL never underflow below 0 nor exceed MAX_SECS; all arithmetic in 8 bits then clamped.

Reset
REQ-031 reset SHALL asynchronously force state=IDLE, time_left=0, cd_digit=0, turbo=0, race_active=0, time_up=0, bonus_pulse=0.
REQ-032 reset asserted mid-race (any state) SHALL abort immediately; no time_up or bonus_pulse emitted on release.
REQ-033 First rising clk after reset release SHALL evaluate inputs normally.

Verification
REQ-034 Reset, start, 3 ticks -> cd_digit 3,2,1,0, state RUN, race_active=1, time_left=60.
REQ-035 RUN, 60 ticks, no other input -> time_left=0, single time_up pulse, state OVER, turbo=0.
REQ-036 RUN time_left=95, add_time add_secs=9 with one_sec same cycle -> time_left=99 (saturated).
REQ-037 RUN, pause, 5 ticks, pause -> time_left unchanged, state RUN, time_up never asserted.
REQ-038 RUN time_left=4, finish with one_sec same cycle -> DRAIN, turbo=1, time_left=4, then 4 ticks give 4 bonus_pulse, state OVER.
REQ-039 Reset asserted in DRAIN mid-cycle -> all outputs cleared without waiting for clk, state IDLE.
